calc_operand_sequencer: RTL
===========================

Name: calc_operand_sequencer

Overview:
- Upstream control stage of the 32-bit calculator datapath (ALU plus result/flag muxes). Collects operand A, operand B and the 4-bit operation code one at a time from board switches, using a single "next" push-button.
- Holds the collected values stable on the calculator inputs and captures the calculator's combinational result and flags into registers.
- Presents the captured values to the display/LED logic.

Parameters:
- N, 32, operand and result width.
- OP_MAX, 10, highest legal operation code (11 operations, codes 0..10).

Ports:
- clk  input  1  system clock; sole clock.
- rst_n  input  1  reset; synchronous, active-low.
- data_in  input  N  switch value; sampled as A, B, or op code (bits [3:0]).
- btn_next  input  1  raw asynchronous push-button level.
- btn_clear  input  1  synchronous clear-to-start, level, active-high.
- a  output  N  operand A to calculator.
- b  output  N  operand B to calculator.
- operacion  output  4  operation code to calculator.
- result_in  input  N  calculator resultado.
- flags_in  input  4  calculator flagsResult.
- result_q  output  N  captured result.
- flags_q  output  4  captured flags.
- done  output  1  high while a captured result is valid.
- err  output  1  illegal op code was entered.
- step  output  3  current state encoding, for LEDs.

Behaviour:
- All state changes on rising clk. rst_n low at an edge: state=S_A; a, b, operacion, result_q, flags_q = 0; done, err = 0. Reset applies in any state, including mid-sequence.
- Button conditioning: btn_next passes through a 2-flop synchroniser, then a rising-edge detector. This produces a one-cycle `press`.
- press timing: btn_next high before edge k gives press high in the cycle after edge k+1. The FSM acts on press at edge k+2.
- A held button yields exactly one press; a new press needs a low level seen by the synchroniser.
- States (step encoding):
  - S_A=0: on press, a<=data_in, go to S_B.
  - S_B=1: on press, b<=data_in, go to S_OP.
  - S_OP=2: on press with data_in[3:0]<=OP_MAX, operacion<=data_in[3:0], err<=0, go to S_EXEC. On press with data_in[3:0]>OP_MAX, operacion unchanged, err<=1, stay in S_OP.
  - S_EXEC=3: exactly one cycle, no press needed. result_q<=result_in, flags_q<=flags_in, done<=1, go to S_SHOW. The calculator is combinational, so a/b/operacion have been stable a full cycle before capture.
  - S_SHOW=4: hold all outputs. On press, done<=0 and go to S_A; a, b, operacion, result_q, flags_q keep their values until overwritten.
- err: set only in S_OP by an illegal code; cleared by a legal op press, by btn_clear, or by reset.
- btn_clear high at an edge, any state: state<=S_A; done, err <=0; result_q, flags_q <=0; a, b, operacion unchanged. Clear wins over a simultaneous press. A press pending in the edge detector during clear is discarded.
- press during S_EXEC is ignored. No edge is lost across the S_SHOW→S_A wrap other than this one.
- data_in is sampled only on the acting edge; changes at other times have no effect.
- Outputs a, b, operacion, result_q, flags_q, done, err, step are all registered; there are no combinational paths input→output.

Decomposition:
- Package calc_pkg holds:
  - state enum typedef (S_A..S_SHOW, 3-bit);
  - OP_MAX and the named op-code constants (OP_SUMA=0, OP_RESTA=1, … OP_MOV=10);
  - default N=32.
- Sub-module btn_edge_sync (2-flop synchroniser + rising-edge detector, clk/rst_n) produces press. It is reused for btn_clear if that is later driven raw.

Test Plan:
- Reset: rst_n=0 for 2 cycles then 1 → step=0, a=b=0, operacion=0, result_q=0, flags_q=0, done=0, err=0.
- Normal add: press with data_in=5, then 3, then 0; bench models result_in=a+b, flags_in=0 → a=5, b=3, operacion=0. One cycle after S_EXEC: result_q=8, flags_q=0, done=1, step=4.
- Illegal op: in S_OP, press with data_in=12 → err=1, step=2, operacion unchanged. Then press with 1 → err=0, operacion=1, proceeds to done.
- Held button: btn_next high for 50 cycles in S_A with data_in=7 → a=7, step=1 only; no advance to S_OP.
- Clear mid-sequence: in S_OP assert btn_clear together with a press-producing edge → step=0, done=0, err=0, a/b retained. Next press loads a.
- Reset mid-operation: rst_n=0 in S_SHOW with result_q=8 → all outputs 0, step=0 at the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand sequencer.
package calc_pkg;

    localparam int unsigned CALC_N = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned STEP_W = 3;

    // Operation codes understood by the calculator datapath
    localparam logic [OP_W-1:0] OP_SUMA  = 4'd0;
    localparam logic [OP_W-1:0] OP_RESTA = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd8;
    localparam logic [OP_W-1:0] OP_CMP   = 4'd9;
    localparam logic [OP_W-1:0] OP_MOV   = 4'd10;
    localparam logic [OP_W-1:0] OP_MAX   = OP_MOV;

    // Sequencer states; the encoding is shown directly on the step LEDs
    typedef enum logic [STEP_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for a raw button.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_c
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronise the raw level and remember the previous synchronised level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press_c = sync2 & ~prev;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Collects A, B and the op code via one button, then captures the calculator result.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned N = CALC_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      data_in,
    input  logic              btn_next,
    input  logic              btn_clear,
    output logic [N-1:0]      a,
    output logic [N-1:0]      b,
    output logic [OP_W-1:0]   operacion,
    input  logic [N-1:0]      result_in,
    input  logic [3:0]        flags_in,
    output logic [N-1:0]      result_q,
    output logic [3:0]        flags_q,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] step
);

    state_t          state;
    state_t          state_d;
    logic [N-1:0]    a_d;
    logic [N-1:0]    b_d;
    logic [OP_W-1:0] op_d;
    logic [N-1:0]    res_d;
    logic [3:0]      flg_d;
    logic            done_d;
    logic            err_d;
    logic            press;

    btn_edge_sync u_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_next),
        .press_c (press)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_A;
            a         <= '0;
            b         <= '0;
            operacion <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            a         <= a_d;
            b         <= b_d;
            operacion <= op_d;
            result_q  <= res_d;
            flags_q   <= flg_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next state and next register values; clear overrides any press
    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        op_d    = operacion;
        res_d   = result_q;
        flg_d   = flags_q;
        done_d  = done;
        err_d   = err;
        if (btn_clear) begin
            state_d = S_A;
            res_d   = '0;
            flg_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state)
                S_A: begin
                    if (press) begin
                        a_d     = data_in;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        b_d     = data_in;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (press) begin
                        if (data_in[OP_W-1:0] <= OP_MAX) begin
                            op_d    = data_in[OP_W-1:0];
                            err_d   = 1'b0;
                            state_d = S_EXEC;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    res_d   = result_in;
                    flg_d   = flags_in;
                    done_d  = 1'b1;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (press) begin
                        done_d  = 1'b0;
                        state_d = S_A;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    assign step = STEP_W'(state);

endmodule
